// File: rtl/and_gate.sv
// Registered bitwise AND of x and y, with all-ones and any-one reduction flags and a valid strobe.
// Latency: LATENCY register stages; a value captured at edge n is on the outputs after edge n+LATENCY-1.
// Backpressure: none; every stage advances every cycle and out_valid alone marks meaningful results.
// Optional: define AND_GATE_COUNT_EN to add match_cnt, a saturating count of presented all-ones results.
module and_gate #(
  parameter int W       = 1,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         in_valid,
  output logic [W-1:0] z,
  output logic         z_all,
  output logic         z_any,
  output logic         out_valid
`ifdef AND_GATE_COUNT_EN
  ,
  output logic [15:0]  match_cnt
`endif
);

  // Catch illegal configurations while elaborating rather than building a broken pipe.
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("and_gate: LATENCY must be in 1..4");
  end
  if (W < 1 || W > 64) begin : g_bad_width
    $error("and_gate: W must be in 1..64");
  end

  // One pipeline stage: the AND result, its reductions and the valid flag travel together.
  typedef struct packed {
    logic [W-1:0] data;
    logic         all;
    logic         any;
    logic         vld;
  } stage_t;

  stage_t         pipe [LATENCY];
  logic   [W-1:0] and_dat;

  assign and_dat = x & y;

  // Stage 0 captures the AND unconditionally; later stages shift; reset flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].data <= and_dat;
      pipe[0].all  <= &and_dat;
      pipe[0].any  <= |and_dat;
      pipe[0].vld  <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign z         = pipe[LATENCY-1].data;
  assign z_all     = pipe[LATENCY-1].all;
  assign z_any     = pipe[LATENCY-1].any;
  assign out_valid = pipe[LATENCY-1].vld;

`ifdef AND_GATE_COUNT_EN
  // Count all-ones results already on the outputs; holds at 0xFFFF instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (out_valid && z_all && (match_cnt != 16'hFFFF)) begin
      match_cnt <= match_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_and_gate.sv
module tb_and_gate;

  logic       clk = 1'b0;
  logic       rst;
  logic       x1, y1, iv1;
  logic       z1, za1, zy1, ov1;
  logic [7:0] x8, y8;
  logic       iv8;
  logic [7:0] z8;
  logic       za8, zy8, ov8;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  and_gate #(.W(1), .LATENCY(1)) u_d1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .in_valid(iv1),
    .z(z1), .z_all(za1), .z_any(zy1), .out_valid(ov1)
  );

  and_gate #(.W(8), .LATENCY(3)) u_d8 (
    .clk(clk), .rst(rst), .x(x8), .y(y8), .in_valid(iv8),
    .z(z8), .z_all(za8), .z_any(zy8), .out_valid(ov8)
  );

`ifdef AND_GATE_COUNT_EN
  logic [3:0]  xc, yc, zc;
  logic        ivc, zac, zyc, ovc;
  logic [15:0] cnt;
  and_gate #(.W(4), .LATENCY(1)) u_dc (
    .clk(clk), .rst(rst), .x(xc), .y(yc), .in_valid(ivc),
    .z(zc), .z_all(zac), .z_any(zyc), .out_valid(ovc), .match_cnt(cnt)
  );
`endif

  typedef struct {
    logic x, y, iv;
    logic z, za, zy, ov;
  } v1_t;

  typedef struct {
    logic [7:0] x, y;
    logic       iv;
    logic [7:0] z;
    logic       za, zy, ov;
  } v8_t;

  v1_t t1[9];
  v8_t t8[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // W=1, LATENCY=1: truth table, then valid gaps.
    t1[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    t1[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    t1[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    t1[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t1[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t1[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    t1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t1[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // W=8, LATENCY=3: each entry's expectation appears two edges after its capture.
    t8[0] = '{8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b1, 1'b1};
    t8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1};
    t8[2] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    t8[3] = '{8'hAA, 8'hFF, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0};
    t8[4] = '{8'h55, 8'h0F, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1};
    t8[5] = '{8'h81, 8'h81, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0};
    t8[6] = '{8'hFF, 8'h7F, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b1};
    t8[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    t8[8] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    // Reset held for two edges with all-ones operands and valid asserted.
    rst = 1'b1;
    x1 = 1'b1; y1 = 1'b1; iv1 = 1'b1;
    x8 = 8'hFF; y8 = 8'hFF; iv8 = 1'b1;
`ifdef AND_GATE_COUNT_EN
    xc = 4'h0; yc = 4'h0; ivc = 1'b0;
`endif
    for (int e = 0; e < 2; e++) begin
      step();
      chk("rst_z1", z1, 0);   chk("rst_za1", za1, 0);
      chk("rst_zy1", zy1, 0); chk("rst_ov1", ov1, 0);
      chk("rst_z8", z8, 0);   chk("rst_za8", za8, 0);
      chk("rst_zy8", zy8, 0); chk("rst_ov8", ov8, 0);
`ifdef AND_GATE_COUNT_EN
      chk("rst_cnt", cnt, 0);
`endif
    end
    rst = 1'b0;
    x1 = 1'b0; y1 = 1'b0; iv1 = 1'b0;

    // W=8 table; the first two outputs are still the flushed reset state.
    for (int i = 0; i < 9; i++) begin
      x8 = t8[i].x; y8 = t8[i].y; iv8 = t8[i].iv;
      step();
      if (i < 2) begin
        chk("post_rst_z8", z8, 0);
        chk("post_rst_ov8", ov8, 0);
      end else begin
        chk($sformatf("t8[%0d].z", i-2),  z8,  t8[i-2].z);
        chk($sformatf("t8[%0d].za", i-2), za8, t8[i-2].za);
        chk($sformatf("t8[%0d].zy", i-2), zy8, t8[i-2].zy);
        chk($sformatf("t8[%0d].ov", i-2), ov8, t8[i-2].ov);
      end
    end

    // W=1 table; LATENCY=1 shows the result right after the capturing edge.
    for (int i = 0; i < 9; i++) begin
      x1 = t1[i].x; y1 = t1[i].y; iv1 = t1[i].iv;
      step();
      chk($sformatf("t1[%0d].z", i),  z1,  t1[i].z);
      chk($sformatf("t1[%0d].za", i), za1, t1[i].za);
      chk($sformatf("t1[%0d].zy", i), zy1, t1[i].zy);
      chk($sformatf("t1[%0d].ov", i), ov1, t1[i].ov);
    end

    // Reset one edge after a valid input on the 3-stage pipe: that result never emerges.
    x8 = 8'hFF; y8 = 8'hFF; iv8 = 1'b1;
    step();
    x8 = 8'h00; y8 = 8'h00; iv8 = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_z8", z8, 0);
    chk("mid_rst_ov8", ov8, 0);
    for (int e = 0; e < 3; e++) begin
      step();
      chk("mid_rst_flush_ov8", ov8, 0);
      chk("mid_rst_flush_z8", z8, 0);
      chk("mid_rst_flush_za8", za8, 0);
    end

`ifdef AND_GATE_COUNT_EN
    // Three all-ones results and one partial: only the full ones count, one cycle late.
    chk("cnt_after_rst", cnt, 0);
    xc = 4'hF; yc = 4'hF; ivc = 1'b1;
    step();
    chk("cnt_lag", cnt, 0);
    chk("cnt_zall", zac, 1);
    step();
    chk("cnt_one", cnt, 1);
    step();
    chk("cnt_two", cnt, 2);
    xc = 4'hF; yc = 4'h7;
    step();
    chk("cnt_partial_z", zc, 4'h7);
    chk("cnt_three", cnt, 3);
    xc = 4'h0; yc = 4'h0; ivc = 1'b0;
    step();
    chk("cnt_hold_a", cnt, 3);
    step();
    chk("cnt_hold_b", cnt, 3);
    // An all-ones result without valid must not count.
    xc = 4'hF; yc = 4'hF; ivc = 1'b0;
    step();
    step();
    chk("cnt_invalid_ignored", cnt, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
- Registered, width-parameterised bitwise AND unit.
- Computes z = x & y per bit and delivers the result through a configurable pipeline with a valid flag.
- Also provides reduction flags: all result bits set, or any result bit set.
- Used as a basic logic primitive in datapaths that need clean, registered AND results aligned to a valid strobe.

Parameters:
- W, 1, operand and result width in bits (1..64).
- LATENCY, 1, number of register stages from inputs to outputs (1..4). 0 is illegal and must be flagged by an elaboration-time check.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- x  input  W  operand A.
- y  input  W  operand B.
- in_valid  input  1  x/y are valid this cycle.
- z  output  W  registered bitwise AND result.
- z_all  output  1  reduction AND of z; 1 when every result bit is 1.
- z_any  output  1  reduction OR of z; 1 when at least one result bit is 1.
- out_valid  output  1  z, z_all and z_any correspond to a sampled valid input.

Behaviour:
- Reset: while rst=1 at a rising edge, every pipeline stage is cleared.
  - z=0, z_all=0, z_any=0, out_valid=0.
  - Outputs stay at these values for the cycle after reset deasserts.
- Per stage 0, the stage-0 register captures:
  - data = x & y, evaluated bitwise;
  - all = &(x & y);
  - any = |(x & y);
  - vld = in_valid.
- Stages 1..LATENCY-1 copy the previous stage unconditionally every cycle (no stall, no backpressure).
- Outputs are driven directly from the last stage; there is no combinational path from x, y or in_valid to any output.
- Latency: a value applied at edge n appears on the outputs after edge n+LATENCY-1. For LATENCY=1 it is visible immediately after the capturing edge.
- Data capture is unconditional:
  - data stages also update when in_valid=0;
  - out_valid alone marks meaningful results;
  - the consumer ignores z when out_valid=0.
- Width 1: z_all and z_any both equal z[0].
- Reset mid-stream: a synchronous rst flushes all stages in the same edge. In-flight results are discarded, and out_valid=0 on the next cycle regardless of prior in_valid.
- rst has priority over all captures in the same cycle.
- X/Z on inputs is not required to be handled; the bench drives only 0/1.

Optional Feature:
- Macro: AND_GATE_COUNT_EN.
- When defined, an extra output port match_cnt (16 bits) is added:
  - it increments by 1 on each edge where out_valid=1 and z_all=1;
  - it saturates at 0xFFFF (no wrap);
  - it clears to 0 on rst;
  - the count reflects outputs already presented, so it lags z_all by one cycle.
- When not defined: the port and counter logic are absent, and the interface is exactly the port list above.

Test Plan:
- Reset: hold rst=1 for 2 edges with x=y=all ones and in_valid=1 -> z=0, z_all=0, z_any=0, out_valid=0 during and one cycle after reset.
- Truth table (W=1, LATENCY=1): apply (x,y) = (0,0), (1,0), (1,1), (0,1), (1,1) with in_valid=1, changing every 20 ns -> z = 0, 0, 1, 0, 1 one edge after each change; out_valid=1.
- Multi-bit (W=8, LATENCY=3): x=0xF0, y=0x3C -> z=0x30, z_all=0, z_any=1 after 2 further edges. Then x=0xFF, y=0xFF -> z=0xFF, z_all=1. Then x=0x0F, y=0xF0 -> z=0x00, z_any=0.
- Valid gaps: alternate in_valid 1/0 with changing operands -> out_valid pattern equals in_valid delayed by LATENCY-1 edges; z still tracks data.
- Reset mid-pipeline (LATENCY=3): assert rst one edge after a valid input -> out_valid never rises for that input; z=0.
- AND_GATE_COUNT_EN: W=4, 3 valid all-ones results plus 1 partial (x=0xF, y=0x7) -> match_cnt=3. Preload via a long run to check saturation at 0xFFFF.
